md_sequencer: RTL and testbench
===============================

MD_SEQUENCER -- requirements
Module: md_sequencer

Interface
REQ-001 Parameter LATENCY, default 33: cycles from the unit start pulse until unit HI/LO are valid; SHALL be >= 1.
REQ-002 Parameter WIDTH, default 32: operand and result width.
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 req  in  1  CPU request to start an operation; sampled only in IDLE.
REQ-006 op  in  1  1 = multiply, 0 = divide (same encoding as the unit's MDControl).
REQ-007 a_in, b_in  in  WIDTH each  operands; sampled with an accepted req.
REQ-008 flush  in  1  abort any in-flight operation.
REQ-009 hi_we, lo_we  in  1 each  MTHI/MTLO write strobes; wdata  in  WIDTH.
REQ-010 busy  out  1  high whenever state != IDLE; the CPU stalls on it.
REQ-011 done  out  1  one-cycle completion pulse.
REQ-012 div0_exc  out  1  one-cycle divide-by-zero flag, coincident with done.
REQ-013 hi_out, lo_out  out  WIDTH each  architectural HI/LO registers.
REQ-014 md_start  out  1;  md_ctrl  out  1;  md_a, md_b  out  WIDTH each  drive the DIVMULT unit.
REQ-015 md_hi, md_lo  in  WIDTH each  results from the DIVMULT unit.

Function
REQ-016 The FSM SHALL use exactly these states: IDLE, START, WAIT, DONE.
REQ-017 IDLE with req=1 and flush=0 SHALL latch op, a_in and b_in, then go to START; the request cycle is cycle 0.
REQ-018 If the accepted op=0 and b_in=0, the FSM SHALL go directly to DONE with the div0 flag set; md_start SHALL never assert.
REQ-019 START (cycle 1): md_start=1 for exactly one cycle; the counter loads LATENCY; next state is WAIT.
REQ-020 WAIT: the counter decrements each cycle; after LATENCY WAIT cycles (cycles 2..LATENCY+1) the FSM SHALL load md_hi/md_lo into hi_out/lo_out and go to DONE.
REQ-021 DONE (cycle LATENCY+2): done=1, with hi_out/lo_out already showing the new values; next state is IDLE; the next req can be accepted at cycle LATENCY+3.
REQ-022 md_ctrl, md_a and md_b SHALL hold the latched op and operands from START through DONE.
REQ-023 div0_exc SHALL equal 1 only in a DONE cycle reached via REQ-018; in that case hi_out/lo_out are unchanged.
REQ-024 flush=1 in any non-IDLE state: next state IDLE, no done pulse, hi_out/lo_out unchanged.
REQ-025 flush=1 and req=1 in IDLE in the same cycle: flush wins and the req is dropped.
REQ-026 req while busy=1 SHALL be ignored, with no queuing.
REQ-027 hi_we/lo_we in IDLE SHALL load wdata into hi_out/lo_out on the next edge.
REQ-028 hi_we/lo_we while busy=1 SHALL be ignored.
REQ-029 hi_we/lo_we together with an accepted req in IDLE: the write takes effect, and the operation result later overwrites it.
REQ-030 The counter width SHALL be $clog2(LATENCY+1) bits and SHALL NOT wrap below zero.

Reset
REQ-031 reset=1 SHALL force state=IDLE, counter=0, and busy, done, div0_exc, md_start, md_ctrl=0.
REQ-032 reset=1 SHALL also clear md_a, md_b, hi_out and lo_out to 0.
REQ-033 Reset SHALL override flush, req and write strobes in the same cycle.
REQ-034 Reset mid-operation SHALL discard the operation silently, with no done pulse.
REQ-035 Reset SHALL NOT reset the DIVMULT unit itself; the enclosing top drives the unit's reset from the same reset signal.

Structure
REQ-036 Shared package md_pkg SHALL hold: the state enum, OP_DIV=0 / OP_MULT=1, and the default MD_LATENCY=33.
REQ-037 md_sequencer SHALL be flat: FSM, counter and HI/LO registers inline.
REQ-038 A thin top md_unit SHALL instantiate md_sequencer plus DIVMULT; it is the only natural sub-module pairing.

Verification
REQ-039 Multiply: reset, then req with op=1, a=7, b=6 -> md_start high at cycle 1 only; done at cycle 35; lo_out=42, hi_out=0; busy high for cycles 1-35.
REQ-040 Divide: req with op=0, a=100, b=7 -> done at cycle 35; lo_out=14, hi_out=2; div0_exc=0.
REQ-041 Divide by zero: req with op=0, a=5, b=0 -> done=1 and div0_exc=1 at cycle 1; md_start never high; HI/LO keep their prior values.
REQ-042 Flush: flush asserted at cycle 10 of a multiply -> busy low at cycle 11; no done pulse; HI/LO unchanged; a new req at cycle 11 is accepted.
REQ-043 Writes: hi_we with wdata=0xDEADBEEF in IDLE -> hi_out=0xDEADBEEF next cycle; lo_we during WAIT -> lo_out unchanged.
REQ-044 Reset and back-to-back: reset at cycle 20 of a divide -> all outputs 0 next cycle with no done; req held high continuously -> accepted once per LATENCY+3 cycles.

Source files
------------

// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide sequencer and its wrapper.
// The state encoding is visible on the sequencer debug port.
package md_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      WAIT  = 2'd2,
      DONE  = 2'd3
   } md_state_e;

   localparam logic OP_DIV  = 1'b0;
   localparam logic OP_MULT = 1'b1;

   localparam int MD_LATENCY = 33;

endpackage

// File: rtl/md_divmult.sv
// Unsigned multiply/divide unit: results are registered on md_start and held,
// so they are stable well before the sequencer samples them.
module md_divmult
   import md_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             ctrl,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0]   hi_q, lo_q;

   assign prod = (2*WIDTH)'(a) * (2*WIDTH)'(b);

   always_ff @(posedge clk) begin
      if (reset) begin
         hi_q <= '0;
         lo_q <= '0;
      end else if (start) begin
         if (ctrl == OP_MULT) begin
            hi_q <= prod[2*WIDTH-1:WIDTH];
            lo_q <= prod[WIDTH-1:0];
         end else if (b != '0) begin
            hi_q <= a % b;
            lo_q <= a / b;
         end else begin
            hi_q <= '0;
            lo_q <= '0;
         end
      end
   end

   assign hi = hi_q;
   assign lo = lo_q;

endmodule

// File: rtl/md_unit.sv
// Pairs the sequencer with the DIVMULT unit; both share the CPU reset.
module md_unit
   import md_pkg::*;
#(
   parameter int LATENCY = MD_LATENCY,
   parameter int WIDTH   = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req,
   input  logic             op,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   input  logic             flush,
   input  logic             hi_we,
   input  logic             lo_we,
   input  logic [WIDTH-1:0] wdata,
   output logic             busy,
   output logic             done,
   output logic             div0_exc,
   output logic [WIDTH-1:0] hi_out,
   output logic [WIDTH-1:0] lo_out,
   output md_state_e        state_o
);

   logic             md_start, md_ctrl;
   logic [WIDTH-1:0] md_a, md_b, md_hi, md_lo;

   md_sequencer #(.LATENCY(LATENCY), .WIDTH(WIDTH)) u_seq (
      .clk(clk), .reset(reset), .req(req), .op(op), .a_in(a_in), .b_in(b_in),
      .flush(flush), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
      .busy(busy), .done(done), .div0_exc(div0_exc), .hi_out(hi_out), .lo_out(lo_out),
      .md_start(md_start), .md_ctrl(md_ctrl), .md_a(md_a), .md_b(md_b),
      .md_hi(md_hi), .md_lo(md_lo), .state_o(state_o)
   );

   md_divmult #(.WIDTH(WIDTH)) u_divmult (
      .clk(clk), .reset(reset), .start(md_start), .ctrl(md_ctrl),
      .a(md_a), .b(md_b), .hi(md_hi), .lo(md_lo)
   );

endmodule

// File: rtl/md_sequencer.sv
// Sequences one multiply/divide through the DIVMULT unit and owns the architectural HI/LO.
// Handshake: req is taken only while busy is low; completion is a one-cycle done pulse.
module md_sequencer
   import md_pkg::*;
#(
   parameter int LATENCY = MD_LATENCY,
   parameter int WIDTH   = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req,
   input  logic             op,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   input  logic             flush,
   input  logic             hi_we,
   input  logic             lo_we,
   input  logic [WIDTH-1:0] wdata,
   output logic             busy,
   output logic             done,
   output logic             div0_exc,
   output logic [WIDTH-1:0] hi_out,
   output logic [WIDTH-1:0] lo_out,
   output logic             md_start,
   output logic             md_ctrl,
   output logic [WIDTH-1:0] md_a,
   output logic [WIDTH-1:0] md_b,
   input  logic [WIDTH-1:0] md_hi,
   input  logic [WIDTH-1:0] md_lo,
   output md_state_e        state_o
);

   localparam int CNT_W = $clog2(LATENCY + 1);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY);

   md_state_e        state_q;
   logic [CNT_W-1:0] cnt_q;
   logic             busy_q, done_q, div0_q, start_q, ctrl_q;
   logic [WIDTH-1:0] a_q, b_q, hi_q, lo_q;

   logic accept, div0_req;

   assign accept   = (state_q == IDLE) && req && !flush;
   assign div0_req = (op == OP_DIV) && (b_in == '0);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         div0_q  <= 1'b0;
         start_q <= 1'b0;
         ctrl_q  <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         done_q  <= 1'b0;
         div0_q  <= 1'b0;
         start_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (hi_we) hi_q <= wdata;
               if (lo_we) lo_q <= wdata;
               if (accept) begin
                  ctrl_q <= op;
                  a_q    <= a_in;
                  b_q    <= b_in;
                  busy_q <= 1'b1;
                  // Divide by zero never reaches the unit; report it straight away.
                  if (div0_req) begin
                     state_q <= DONE;
                     done_q  <= 1'b1;
                     div0_q  <= 1'b1;
                  end else begin
                     state_q <= START;
                     start_q <= 1'b1;
                  end
               end
            end
            START: begin
               if (flush) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end else begin
                  cnt_q   <= CNT_LOAD;
                  state_q <= WAIT;
               end
            end
            WAIT: begin
               if (flush) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
                  cnt_q   <= '0;
               end else begin
                  if (cnt_q != '0) cnt_q <= cnt_q - CNT_W'(1);
                  // Count of 1 marks the last wait cycle: capture the result now.
                  if (cnt_q <= CNT_W'(1)) begin
                     hi_q    <= md_hi;
                     lo_q    <= md_lo;
                     done_q  <= 1'b1;
                     state_q <= DONE;
                  end
               end
            end
            DONE: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign div0_exc = div0_q;
   assign md_start = start_q;
   assign md_ctrl  = ctrl_q;
   assign md_a     = a_q;
   assign md_b     = b_q;
   assign hi_out   = hi_q;
   assign lo_out   = lo_q;
   assign state_o  = state_q;

endmodule

// File: tb/tb_md_sequencer.sv
// Directed bench for md_sequencer with a behavioural DIVMULT model on the unit side.
module tb_md_sequencer;
   import md_pkg::*;

   localparam int W = 32;
   localparam int L = MD_LATENCY;

   logic          clk, reset, req, op, flush, hi_we, lo_we;
   logic [W-1:0]  a_in, b_in, wdata;
   logic          busy, done, div0_exc, md_start, md_ctrl;
   logic [W-1:0]  hi_out, lo_out, md_a, md_b, md_hi, md_lo;
   md_state_e     state_o;

   md_sequencer #(.LATENCY(L), .WIDTH(W)) dut (
      .clk(clk), .reset(reset), .req(req), .op(op), .a_in(a_in), .b_in(b_in),
      .flush(flush), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
      .busy(busy), .done(done), .div0_exc(div0_exc), .hi_out(hi_out), .lo_out(lo_out),
      .md_start(md_start), .md_ctrl(md_ctrl), .md_a(md_a), .md_b(md_b),
      .md_hi(md_hi), .md_lo(md_lo), .state_o(state_o)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // unit model: result of whatever operands the sequencer presents
   always_comb begin
      md_hi = '0;
      md_lo = '0;
      if (md_ctrl == OP_MULT) begin
         {md_hi, md_lo} = 64'(md_a) * 64'(md_b);
      end else if (md_b != '0) begin
         md_lo = md_a / md_b;
         md_hi = md_a % md_b;
      end
   end

   typedef struct {
      logic         op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] exp_hi;
      logic [W-1:0] exp_lo;
      logic         exp_div0;
      int           exp_done;
   } vec_t;

   vec_t        vecs[5];
   int          checks = 0;
   int          errors = 0;
   logic [63:0] exp_q[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      req = 0; op = 0; a_in = '0; b_in = '0; flush = 0;
      hi_we = 0; lo_we = 0; wdata = '0; reset = 0;
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_busy"},  64'(busy), 64'd0);
      check({tag, "_done"},  64'(done), 64'd0);
      check({tag, "_div0"},  64'(div0_exc), 64'd0);
      check({tag, "_start"}, 64'(md_start), 64'd0);
      check({tag, "_ctrl"},  64'(md_ctrl), 64'd0);
      check({tag, "_md_a"},  64'(md_a), 64'd0);
      check({tag, "_md_b"},  64'(md_b), 64'd0);
      check({tag, "_hi"},    64'(hi_out), 64'd0);
      check({tag, "_lo"},    64'(lo_out), 64'd0);
      check({tag, "_state"}, 64'(state_o), 64'(IDLE));
   endtask

   // waits from cycle c0 until done is seen; dc = -1 on timeout
   task automatic wait_done(input int c0, output int dc);
      dc = -1;
      for (int c = c0; c < c0 + 100; c++) begin
         if (done) begin
            dc = c;
            break;
         end
         step();
      end
   endtask

   // driver: issues one request (cycle 0) and follows it to completion and back to IDLE
   task automatic run_op(input logic o, input logic [W-1:0] a, input logic [W-1:0] b,
                         output int dc, output int starts, output int first_start,
                         output int busy_low, output logic d0,
                         output logic [W-1:0] hi, output logic [W-1:0] lo,
                         output logic [W-1:0] ma, output logic [W-1:0] mb, output logic mc);
      dc = -1; starts = 0; first_start = -1; busy_low = 0;
      d0 = 0; hi = '0; lo = '0; ma = '0; mb = '0; mc = 0;
      req = 1; op = o; a_in = a; b_in = b;
      step();
      req = 0;
      for (int c = 1; c < 100; c++) begin
         if (md_start) begin
            starts++;
            if (first_start < 0) first_start = c;
         end
         if (!busy) busy_low++;
         if (done) begin
            dc = c; d0 = div0_exc; hi = hi_out; lo = lo_out;
            ma = md_a; mb = md_b; mc = md_ctrl;
            break;
         end
         step();
      end
      step();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int dc, starts, first_start, busy_low, dcount;
      logic d0, mc;
      logic [W-1:0] hi, lo, ma, mb;
      logic [63:0] exp;
      int start_cyc[$];

      vecs[0] = '{1'b1, 32'd7,          32'd6,    32'd0, 32'd42,         1'b0, L + 2};
      vecs[1] = '{1'b0, 32'd100,        32'd7,    32'd2, 32'd14,         1'b0, L + 2};
      vecs[2] = '{1'b0, 32'd5,          32'd0,    32'd2, 32'd14,         1'b1, 1};
      vecs[3] = '{1'b1, 32'hFFFF_FFFF,  32'd2,    32'd1, 32'hFFFF_FFFE,  1'b0, L + 2};
      vecs[4] = '{1'b0, 32'hFFFF_FFFF,  32'h10,   32'hF, 32'h0FFF_FFFF,  1'b0, L + 2};

      // reset overrides simultaneous req, flush and writes
      idle_inputs();
      reset = 1; req = 1; op = 1; a_in = 32'd9; b_in = 32'd9;
      flush = 1; hi_we = 1; lo_we = 1; wdata = 32'h1234_5678;
      step();
      step();
      check_zero("reset");
      idle_inputs();
      step();

      foreach (vecs[i]) begin
         exp_q.push_back({vecs[i].exp_hi, vecs[i].exp_lo});
         run_op(vecs[i].op, vecs[i].a, vecs[i].b, dc, starts, first_start, busy_low,
                d0, hi, lo, ma, mb, mc);
         check($sformatf("v%0d_done_cycle", i), 64'(dc), 64'(vecs[i].exp_done));
         check($sformatf("v%0d_starts", i), 64'(starts), vecs[i].exp_div0 ? 64'd0 : 64'd1);
         if (!vecs[i].exp_div0) begin
            check($sformatf("v%0d_start_cycle", i), 64'(first_start), 64'd1);
            check($sformatf("v%0d_md_a", i), 64'(ma), 64'(vecs[i].a));
            check($sformatf("v%0d_md_b", i), 64'(mb), 64'(vecs[i].b));
            check($sformatf("v%0d_md_ctrl", i), 64'(mc), 64'(vecs[i].op));
         end
         check($sformatf("v%0d_busy_gap", i), 64'(busy_low), 64'd0);
         check($sformatf("v%0d_div0", i), 64'(d0), 64'(vecs[i].exp_div0));
         exp = exp_q.pop_front();
         check($sformatf("v%0d_hilo", i), {hi, lo}, exp);
         check($sformatf("v%0d_idle_after", i), 64'(busy), 64'd0);
      end

      // MTHI in IDLE, then MTLO and a stray req during WAIT are both ignored
      hi_we = 1; wdata = 32'hDEAD_BEEF;
      step();
      hi_we = 0;
      check("mthi_idle", 64'(hi_out), 64'hDEAD_BEEF);
      req = 1; op = 1; a_in = 32'd3; b_in = 32'd5;
      step();
      req = 0;
      step(); step(); step();
      lo_we = 1; wdata = 32'h0000_1234; req = 1; a_in = 32'd100; b_in = 32'd100;
      step();
      lo_we = 0; req = 0;
      check("mtlo_busy", 64'(lo_out), 64'h0FFF_FFFF);
      check("mthi_held", 64'(hi_out), 64'hDEAD_BEEF);
      wait_done(5, dc);
      check("mul3x5_done_cycle", 64'(dc), 64'(L + 2));
      check("mul3x5_hilo", {hi_out, lo_out}, {32'd0, 32'd15});
      starts = 0; dcount = 0;
      for (int k = 0; k < L + 5; k++) begin
         step();
         if (md_start) starts++;
         if (done) dcount++;
      end
      check("busy_req_not_queued", 64'(starts + dcount), 64'd0);

      // flush at cycle 10 of a multiply, new request at cycle 11
      req = 1; op = 1; a_in = 32'd9; b_in = 32'd9;
      step();
      req = 0;
      dcount = 0;
      for (int c = 2; c <= 10; c++) begin
         step();
         if (done) dcount++;
      end
      flush = 1;
      step();
      flush = 0;
      check("flush_busy", 64'(busy), 64'd0);
      check("flush_no_done", 64'(dcount + int'(done)), 64'd0);
      check("flush_hilo", {hi_out, lo_out}, {32'd0, 32'd15});
      run_op(1'b0, 32'd50, 32'd5, dc, starts, first_start, busy_low, d0, hi, lo, ma, mb, mc);
      check("post_flush_done_cycle", 64'(dc), 64'(L + 2));
      check("post_flush_hilo", {hi, lo}, {32'd0, 32'd10});

      // flush and req together in IDLE: the req is dropped
      req = 1; flush = 1; op = 1; a_in = 32'd1; b_in = 32'd1;
      step();
      req = 0; flush = 0;
      check("flush_req_busy", 64'(busy), 64'd0);
      check("flush_req_start", 64'(md_start), 64'd0);

      // MTHI together with an accepted req: write lands, result overwrites it
      hi_we = 1; wdata = 32'hAAAA_5555; req = 1; op = 1; a_in = 32'd2; b_in = 32'd3;
      step();
      hi_we = 0; req = 0;
      check("mthi_with_req", 64'(hi_out), 64'hAAAA_5555);
      wait_done(1, dc);
      check("mthi_req_done_cycle", 64'(dc), 64'(L + 2));
      check("mthi_req_hilo", {hi_out, lo_out}, {32'd0, 32'd6});
      step();

      // reset at cycle 20 of a divide
      req = 1; op = 0; a_in = 32'd100; b_in = 32'd3;
      step();
      req = 0;
      for (int c = 2; c <= 20; c++) step();
      reset = 1;
      step();
      reset = 0;
      check_zero("midop_reset");
      dcount = 0;
      for (int k = 0; k < L + 5; k++) begin
         step();
         if (done || busy) dcount++;
      end
      check("midop_reset_silent", 64'(dcount), 64'd0);

      // req held high: one acceptance every L+3 cycles
      req = 1; op = 1; a_in = 32'd4; b_in = 32'd4;
      dcount = 0;
      for (int c = 1; c <= 3 * (L + 3); c++) begin
         step();
         if (md_start) start_cyc.push_back(c);
         if (done) dcount++;
      end
      req = 0;
      step();
      check("b2b_starts", 64'(start_cyc.size()), 64'd3);
      check("b2b_dones", 64'(dcount), 64'd3);
      if (start_cyc.size() == 3) begin
         check("b2b_first", 64'(start_cyc[0]), 64'd1);
         check("b2b_period1", 64'(start_cyc[1] - start_cyc[0]), 64'(L + 3));
         check("b2b_period2", 64'(start_cyc[2] - start_cyc[1]), 64'(L + 3));
      end
      check("b2b_final_idle", 64'(busy), 64'd0);
      check("b2b_lo", 64'(lo_out), 64'd16);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
